sensor_cmd_scheduler: RTL



---
 rtl/sensor_cmd_pkg.sv | 46 ++++
 rtl/sensor_cmd_scheduler_pulse_sync.sv | 13 +
 rtl/sensor_cmd_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sensor_cmd_pkg.sv
// sensor_cmd_pkg: command/response codes, FSM encoding and sensor frame layout.
package sensor_cmd_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_TEMP   = 8'h01;
  localparam logic [7:0] CMD_HUM    = 8'h02;
  localparam logic [7:0] CMD_CT_ON  = 8'h03;
  localparam logic [7:0] CMD_CH_ON  = 8'h04;
  localparam logic [7:0] CMD_CT_OFF = 8'h05;
  localparam logic [7:0] CMD_CH_OFF = 8'h06;

  localparam logic [7:0] RSP_OK     = 8'h07;
  localparam logic [7:0] RSP_HUM    = 8'h08;
  localparam logic [7:0] RSP_TEMP   = 8'h09;
  localparam logic [7:0] RSP_CT_OFF = 8'h0A;
  localparam logic [7:0] RSP_CH_OFF = 8'h0B;
  localparam logic [7:0] RSP_FAIL   = 8'h1F;
  localparam logic [7:0] RSP_BAD    = 8'hFF;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SENSE       = 3'd1;
  localparam logic [2:0] S_WAIT_SENSOR = 3'd2;
  localparam logic [2:0] S_TX0         = 3'd3;
  localparam logic [2:0] S_WAIT_TX0    = 3'd4;
  localparam logic [2:0] S_TX1         = 3'd5;
  localparam logic [2:0] S_WAIT_TX1    = 3'd6;

  localparam int HUM_INT_LSB   = 32;
  localparam int HUM_FRAC_LSB  = 24;
  localparam int TEMP_INT_LSB  = 16;
  localparam int TEMP_FRAC_LSB = 8;
  localparam int CSUM_LSB      = 0;

  typedef enum logic [1:0] {RD_STATUS, RD_TEMP, RD_HUM} read_kind_t;

  function automatic logic [7:0] field(input logic [39:0] d, input int lsb);
    return d[lsb +: 8];
  endfunction

  function automatic logic csum_ok(input logic [39:0] d);
    logic [7:0] s;
    s = field(d, HUM_INT_LSB) + field(d, HUM_FRAC_LSB) + field(d, TEMP_INT_LSB) + field(d, TEMP_FRAC_LSB);
    return s == field(d, CSUM_LSB);
  endfunction

endpackage

// File: rtl/sensor_cmd_scheduler_pulse_sync.sv
// pulse_sync: two-flop synchronizer with a one-cycle rising-edge pulse.
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[1:0], din};
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/sensor_cmd_scheduler.sv
// sensor_cmd_scheduler: decodes host frames and periodic ticks into sensor reads
// and two-byte responses handed to the UART transmitter.
module sensor_cmd_scheduler
  import sensor_cmd_pkg::*;
#(
  parameter int PERIOD_CYCLES = 50_000_000,
  parameter int NUM_SENSORS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rx_data,
  input  logic        rx_done,
  output logic        sensor_req,
  output logic [4:0]  sensor_addr,
  input  logic        sensor_ack,
  input  logic [39:0] sensor_data,
  input  logic        sensor_err,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        cont_temp,
  output logic        cont_hum,
  output logic        overrun
);
  localparam int TW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;

  logic             rx_pulse;
  logic             slot_valid;
  logic [15:0]      slot_data;
  logic             take;
  logic [7:0]       cmd;
  logic [7:0]       addr;
  logic             addr_ok;
  logic             rd_ok;
  logic [2:0]       state;
  read_kind_t       kind;
  logic [7:0]       rsp_code;
  logic [7:0]       rsp_val;
  logic             seen_busy;
  logic             is_tick;
  logic             tick_hum;
  logic             tick_pending;
  logic [4:0]       cont_addr;
  logic [TW-1:0]    timer;

  pulse_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx_done),
    .pulse (rx_pulse)
  );

  assign cmd        = slot_data[7:0];
  assign addr       = slot_data[15:8];
  assign addr_ok    = int'(addr) < NUM_SENSORS;
  assign take       = state == S_IDLE && slot_valid;
  assign rd_ok      = !sensor_err && csum_ok(sensor_data);
  assign sensor_req = state == S_SENSE || state == S_WAIT_SENSOR;
  assign tx_start   = (state == S_TX0 || state == S_TX1) && !tx_busy;
  assign tx_byte    = state == S_TX0 ? rsp_code : state == S_TX1 ? rsp_val : 8'h00;

  // A frame arriving in the same cycle the slot is drained refills it instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
      overrun    <= 1'b0;
    end else if (rx_pulse) begin
      if (slot_valid && !take) overrun <= 1'b1;
      else begin
        slot_data  <= rx_data;
        slot_valid <= 1'b1;
      end
    end else if (take) slot_valid <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      kind         <= RD_STATUS;
      rsp_code     <= '0;
      rsp_val      <= '0;
      seen_busy    <= 1'b0;
      is_tick      <= 1'b0;
      tick_hum     <= 1'b0;
      tick_pending <= 1'b0;
      cont_temp    <= 1'b0;
      cont_hum     <= 1'b0;
      cont_addr    <= '0;
      sensor_addr  <= '0;
      timer        <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (slot_valid) begin
            is_tick <= 1'b0;
            if (!addr_ok || cmd > CMD_CH_OFF) begin
              {rsp_code, rsp_val} <= {RSP_BAD, 8'h00};
              state <= S_TX0;
            end else if (cmd == CMD_CT_OFF) begin
              cont_temp <= 1'b0;
              {rsp_code, rsp_val} <= {RSP_CT_OFF, 8'h00};
              state <= S_TX0;
            end else if (cmd == CMD_CH_OFF) begin
              cont_hum <= 1'b0;
              {rsp_code, rsp_val} <= {RSP_CH_OFF, 8'h00};
              state <= S_TX0;
            end else begin
              sensor_addr <= addr[4:0];
              kind <= cmd == CMD_STATUS ? RD_STATUS : (cmd == CMD_TEMP || cmd == CMD_CT_ON) ? RD_TEMP : RD_HUM;
              if (cmd == CMD_CT_ON) cont_temp <= 1'b1;
              if (cmd == CMD_CH_ON) cont_hum <= 1'b1;
              if (cmd == CMD_CT_ON || cmd == CMD_CH_ON) cont_addr <= addr[4:0];
              state <= S_SENSE;
            end
          end else if (tick_pending) begin
            // tick_hum marks that the temperature half of a dual-mode tick is done
            if (cont_temp && !tick_hum) begin
              kind        <= RD_TEMP;
              is_tick     <= 1'b1;
              sensor_addr <= cont_addr;
              state       <= S_SENSE;
            end else if (cont_hum) begin
              kind        <= RD_HUM;
              is_tick     <= 1'b1;
              sensor_addr <= cont_addr;
              state       <= S_SENSE;
            end else begin
              tick_pending <= 1'b0;
              tick_hum     <= 1'b0;
            end
          end
        S_SENSE: state <= S_WAIT_SENSOR;
        S_WAIT_SENSOR:
          if (sensor_ack) begin
            rsp_code <= !rd_ok ? RSP_FAIL : kind == RD_STATUS ? RSP_OK : kind == RD_TEMP ? RSP_TEMP : RSP_HUM;
            rsp_val  <= (!rd_ok || kind == RD_STATUS) ? 8'h00 :
                        kind == RD_TEMP ? field(sensor_data, TEMP_INT_LSB) : field(sensor_data, HUM_INT_LSB);
            state    <= S_TX0;
          end
        S_TX0, S_TX1:
          if (!tx_busy) begin
            seen_busy <= 1'b0;
            state     <= state == S_TX0 ? S_WAIT_TX0 : S_WAIT_TX1;
          end
        S_WAIT_TX0:
          if (tx_busy) seen_busy <= 1'b1;
          else if (seen_busy) state <= S_TX1;
        S_WAIT_TX1:
          if (tx_busy) seen_busy <= 1'b1;
          else if (seen_busy) begin
            state <= S_IDLE;
            if (is_tick) begin
              if (kind == RD_TEMP && cont_hum) tick_hum <= 1'b1;
              else begin
                tick_pending <= 1'b0;
                tick_hum     <= 1'b0;
              end
            end
          end
        default: state <= S_IDLE;
      endcase
      // a wrap in the same cycle as a tick completes must win, so this comes last
      if (!(cont_temp || cont_hum)) timer <= '0;
      else if (timer == TW'(PERIOD_CYCLES - 1)) begin
        timer        <= '0;
        tick_pending <= 1'b1;
      end else timer <= timer + TW'(1);
    end
  end

endmodule
